// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU; single-cycle ops answer one cycle after accept.
// Define ALU_SEQ_MULDIV_EN to add iterative MUL/MULHU/DIVU/REMU (WIDTH+1 cycle latency).
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_aluIllegal;
    logic             w_isMulDiv;
    logic [SHW-1:0]   w_shamt;
    logic             w_accept;

    assign w_shamt   = input2[SHW-1:0];
    assign w_accept  = (r_state == IDLE) && in_valid;
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

    always_comb begin
        w_aluResult  = '0;
        w_aluIllegal = 1'b0;
        w_isMulDiv   = 1'b0;
        case (op)
            4'b0000: w_aluResult = input1 & input2;
            4'b0001: w_aluResult = input1 | input2;
            4'b0010: w_aluResult = input1 + input2;
            4'b0110: w_aluResult = input1 - input2;
            4'b0011: w_aluResult = input1 ^ input2;
            4'b0100: w_aluResult = input1 << w_shamt;
            4'b0101: w_aluResult = input1 >> w_shamt;
            4'b0111: w_aluResult = $unsigned($signed(input1) >>> w_shamt);
            4'b1000: w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            4'b1001: w_aluResult = {{(WIDTH-1){1'b0}}, (input1 < input2)};
`ifdef ALU_SEQ_MULDIV_EN
            4'b1010, 4'b1011, 4'b1100, 4'b1101: w_isMulDiv = 1'b1;
`endif
            default: w_aluIllegal = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic [SHW:0]       r_count;
    logic               r_isDiv;
    logic               r_sel;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_prodNext;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH-1:0]   w_remSub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quotNext;
    logic [WIDTH-1:0]   w_mdResult;

    // Shift-add multiply: multiplier sits in the low half of r_prod and drains out to the right.
    assign w_mulSum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
    assign w_prodNext = {w_mulSum, r_prod[WIDTH-1:1]};

    // Restoring divide; a zero divisor naturally yields all-ones quotient and remainder = dividend.
    assign w_remShift = {r_rem, r_quot[WIDTH-1]};
    assign w_ge       = (w_remShift >= {1'b0, r_opnd});
    assign w_remSub   = w_remShift[WIDTH-1:0] - r_opnd;
    assign w_remNext  = w_ge ? w_remSub : w_remShift[WIDTH-1:0];
    assign w_quotNext = {r_quot[WIDTH-2:0], w_ge};
    assign w_mdResult = r_isDiv ? (r_sel ? w_remNext : w_quotNext)
                                : (r_sel ? w_prodNext[2*WIDTH-1:WIDTH] : w_prodNext[WIDTH-1:0]);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nextState = w_isMulDiv ? BUSY : DONE;
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            BUSY: begin
                if (r_count == (SHW+1)'(1)) begin
                    w_nextState = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The last iteration writes its result directly so the BUSY phase spans exactly WIDTH cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_sel     <= 1'b0;
            r_opnd    <= '0;
            r_prod    <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
`endif
        end else begin
            if (w_accept && !w_isMulDiv) begin
                r_result  <= w_aluResult;
                r_zero    <= (w_aluResult == '0);
                r_illegal <= w_aluIllegal;
            end
`ifdef ALU_SEQ_MULDIV_EN
            if (w_accept && w_isMulDiv) begin
                r_isDiv <= op[2];
                r_sel   <= op[0];
                r_opnd  <= op[2] ? input2 : input1;
                r_prod  <= {{WIDTH{1'b0}}, input2};
                r_quot  <= input1;
                r_rem   <= '0;
                r_count <= (SHW+1)'(WIDTH);
            end
            if (r_state == BUSY) begin
                if (r_isDiv) begin
                    r_rem  <= w_remNext;
                    r_quot <= w_quotNext;
                end else begin
                    r_prod <= w_prodNext;
                end
                r_count <= r_count - 1'b1;
                if (r_count == (SHW+1)'(1)) begin
                    r_result  <= w_mdResult;
                    r_zero    <= (w_mdResult == '0);
                    r_illegal <= 1'b0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq; expectations come from a bench-side reference model.
module tb_alu_seq;
    localparam int WIDTH = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [3:0]        op = 4'd0;
    logic [WIDTH-1:0]  input1 = '0;
    logic [WIDTH-1:0]  input2 = '0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic              illegal;

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checkCount = 0;
    int   passCount  = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [127:0] wide;
        e.res  = '0;
        e.ill  = 1'b0;
        e.lat  = 1;
        wide   = '0;
        case (o)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  e.res = a + b;
            4'd6:  e.res = a - b;
            4'd3:  e.res = a ^ b;
            4'd4:  e.res = a << b[5:0];
            4'd5:  e.res = a >> b[5:0];
            4'd7: begin
                wide  = {{64{a[63]}}, a} >> b[5:0];
                e.res = wide[63:0];
            end
            4'd8:  e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9:  e.res = (a < b) ? 64'd1 : 64'd0;
`ifdef ALU_SEQ_MULDIV_EN
            4'd10, 4'd11: begin
                wide  = {64'd0, a} * {64'd0, b};
                e.res = (o == 4'd10) ? wide[63:0] : wide[127:64];
                e.lat = WIDTH + 1;
            end
            4'd12: begin
                e.res = (b == 0) ? {64{1'b1}} : a / b;
                e.lat = WIDTH + 1;
            end
            4'd13: begin
                e.res = (b == 0) ? a : a % b;
                e.lat = WIDTH + 1;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic applyStimulus(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        int waitCyc = 0;
        @(negedge clk);
        op       = o;
        input1   = a;
        input2   = b;
        in_valid = 1'b1;
        sb.push_back(model(o, a, b));
        while (!in_ready && waitCyc < 200) begin
            @(negedge clk);
            waitCyc++;
        end
        check("accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int hold);
        exp_t e;
        int   lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        e = sb.pop_front();
        check({tag, ".lat"}, lat, e.lat);
        check({tag, ".result"}, result, e.res);
        check({tag, ".zero"}, zero, e.zero);
        check({tag, ".illegal"}, illegal, e.ill);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, ".holdResult"}, result, e.res);
            check({tag, ".holdZero"}, zero, e.zero);
            check({tag, ".holdInReady"}, in_ready, 0);
            check({tag, ".holdOutValid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, ".drainValid"}, out_valid, 0);
        check({tag, ".drainReady"}, in_ready, 1);
    endtask

    initial begin
        $display("[TB] alu_seq bench start");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst.outValid", out_valid, 0);
        check("rst.inReady", in_ready, 1);
        check("rst.result", result, 0);
        check("rst.zero", zero, 0);
        check("rst.illegal", illegal, 0);

        applyStimulus(4'd2, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB);
        checkOutput("add", 0);
        applyStimulus(4'd7, 64'h8000_0000_0000_0000, 64'h43);
        checkOutput("sra", 0);
        applyStimulus(4'd8, {64{1'b1}}, 64'd1);
        checkOutput("slt", 0);
        applyStimulus(4'd9, {64{1'b1}}, 64'd1);
        checkOutput("sltu", 0);
        applyStimulus(4'd0, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
        checkOutput("and", 0);
        applyStimulus(4'd1, 64'hF000_0000_0000_0001, 64'h0000_0000_0000_0100);
        checkOutput("or", 0);
        applyStimulus(4'd3, 64'hAAAA_AAAA_5555_5555, 64'hFFFF_0000_FFFF_0000);
        checkOutput("xor", 0);
        applyStimulus(4'd4, 64'h0000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FFC4);
        checkOutput("sll", 0);
        applyStimulus(4'd5, 64'h8000_0000_0000_0000, 64'd63);
        checkOutput("srl", 0);
        applyStimulus(4'd6, 64'd3, 64'd3);
        checkOutput("subHold", 10);
        applyStimulus(4'd6, 64'd0, 64'd1);
        checkOutput("subWrap", 0);
        applyStimulus(4'd14, 64'd7, 64'd9);
        checkOutput("ill14", 0);
        applyStimulus(4'd15, 64'd1, 64'd1);
        checkOutput("ill15", 0);

        applyStimulus(4'd10, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        checkOutput("mul", 0);
        applyStimulus(4'd11, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        checkOutput("mulhu", 0);
        applyStimulus(4'd11, {64{1'b1}}, 64'd3);
        checkOutput("mulhuBig", 0);
        applyStimulus(4'd12, 64'd100, 64'd7);
        checkOutput("divu", 0);
        applyStimulus(4'd13, 64'd100, 64'd7);
        checkOutput("remu", 3);
        applyStimulus(4'd12, 64'h1234_5678_9ABC_DEF0, 64'd0);
        checkOutput("divu0", 0);
        applyStimulus(4'd13, 64'd9, 64'd0);
        checkOutput("remu0", 0);

        applyStimulus(4'd12, 64'd1000, 64'd3);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        void'(sb.pop_front());
        @(negedge clk);
        check("midRst.outValid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midRst.inReady", in_ready, 1);
        check("midRst.outValid2", out_valid, 0);
        check("midRst.result", result, 0);
        check("midRst.illegal", illegal, 0);
        applyStimulus(4'd2, 64'd2, 64'd2);
        checkOutput("addAfterRst", 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
